controller_sequencer: RTL and testbench
=======================================

// Module: controller_sequencer
// PURPOSE
//  SAP-1 controller/sequencer: the consuming end of the instruction register interface.
//  It takes the registered 4-bit opcode and steps a T1..T6 ring counter.
//  Each step it drives the one-hot-per-signal control word to all bus agents, including
//  the IR load and IR send-address strobes.
//  It sits between the IR and the PC, MAR, RAM, A, B, ALU and OUT registers.
// PARAMETERS
//  OP_LDA  4'b0000  load A from RAM[addr]
//  OP_ADD  4'b0001  A <= A + RAM[addr]
//  OP_SUB  4'b0010  A <= A - RAM[addr]
//  OP_OUT  4'b1110  OUT <= A
//  OP_HLT  4'b1111  stop sequencing
// PORTS
//  i_clk             in   1  system clock; state advances on rising edge
//  i_reset_n         in   1  async active-low reset
//  i_debug           in   1  enables $display trace of each T-state (sim only)
//  i_opcode          in   4  opcode from the instruction register
//  o_tstate          out  6  one-hot ring state, bit0=T1 .. bit5=T6
//  o_pc_inc          out  1  increment PC (Cp)
//  o_pc_out          out  1  PC drives bus (Ep)
//  o_mar_load        out  1  MAR loads from bus (Lm)
//  o_ram_out         out  1  RAM drives bus (CE)
//  o_ir_load         out  1  IR loads from bus (Li)
//  o_ir_send_address out  1  IR drives low nibble to bus (Ei)
//  o_a_load          out  1  A loads from bus (La)
//  o_a_out           out  1  A drives bus (Ea)
//  o_alu_sub         out  1  ALU subtract select (Su)
//  o_alu_out         out  1  ALU drives bus (Eu)
//  o_b_load          out  1  B loads from bus (Lb)
//  o_out_load        out  1  OUT register loads from bus (Lo)
//  o_halt            out  1  sticky halt flag
// BEHAVIOUR
//  - All control outputs are active-high.
//  - Reset (i_reset_n=0, async): o_tstate=6'b000001 (T1), o_halt=0.
//    All control outputs are forced 0 while reset is asserted, regardless of state.
//  - First rising edge after release: T1 -> T2.
//  - Ring: T1->T2->...->T6->T1, one state per clock.
//  - Control word decode: combinational from o_tstate and i_opcode (Moore per T-state):
//    T1 all ops: pc_out, mar_load
//    T2 all ops: pc_inc
//    T3 all ops: ram_out, ir_load
//    T4 LDA/ADD/SUB: ir_send_address, mar_load | OUT: a_out, out_load | HLT: none
//    T5 LDA: ram_out, a_load | ADD/SUB: ram_out, b_load | others: none
//    T6 ADD: alu_out, a_load | SUB: alu_sub, alu_out, a_load | others: none
//  - i_opcode is used only in T4..T6; it is stable there because the IR loads in T3.
//  - Undefined opcodes execute T4..T6 with an all-zero control word (NOP).
//  - HLT: the clock edge that leaves T4 with i_opcode==OP_HLT sets o_halt=1 and freezes o_tstate.
//    While halted, all control outputs are 0 and further clocks are ignored.
//    Only reset clears the halt.
//  - At most one bus driver (pc_out, ram_out, ir_send_address, a_out, alu_out) is active in any state.
//  - Reset asserted mid-instruction aborts it immediately; the next fetch starts at T1.
//  - i_debug=1: one $display per state change, "DEBUG: CS T<n> op=<bin>".
// CONFIGURATION
//  CTRL_SKIP_NOP_EN defined:
//    - LDA returns T5->T1.
//    - OUT and undefined opcodes return T4->T1.
//    - ADD and SUB keep the full 6 states.
//  CTRL_SKIP_NOP_EN undefined: every instruction takes exactly 6 clocks.
// TESTING
//  1. Reset with i_reset_n=0 at any state -> o_tstate=000001, all controls 0, o_halt=0.
//     Release, 6 clocks -> states T1..T6 visited once, back to T1.
//  2. LDA (op 0000) -> controls per cycle:
//     T1 {pc_out,mar_load}, T2 {pc_inc}, T3 {ram_out,ir_load},
//     T4 {ir_send_address,mar_load}, T5 {ram_out,a_load}, T6 none.
//  3. SUB (op 0010) -> T6 = {alu_sub,alu_out,a_load}.
//     ADD (op 0001) -> T6 = {alu_out,a_load}, alu_sub=0.
//  4. HLT (op 1111) -> after T4, o_halt=1 and o_tstate stays 001000 for 20 clocks, controls 0.
//     Then i_reset_n=0 -> o_halt=0, T1.
//  5. Bus-contention check: all 16 opcodes x 6 states -> count of active bus drivers <= 1.
//     Op 0111 yields zero controls in T4..T6.
//  6. With CTRL_SKIP_NOP_EN: OUT takes 4 clocks and LDA 5 clocks per instruction,
//     ADD still 6, verified by T1 recurrence spacing.

Source files
------------

// File: rtl/controller_sequencer_if.sv
// ---------------------------------------------------------------------------
// controller_sequencer_if
// Purpose : SAP-1 control bus between the controller/sequencer and the bus
//           agents (IR, PC, MAR, RAM, A, B, ALU, OUT). It carries the opcode
//           from the instruction register and the active-high control word
//           that goes back to every agent.
// Signals :
//   i_opcode          4  opcode from the instruction register
//   o_pc_inc          1  increment PC (Cp)
//   o_pc_out          1  PC drives bus (Ep)
//   o_mar_load        1  MAR loads from bus (Lm)
//   o_ram_out         1  RAM drives bus (CE)
//   o_ir_load         1  IR loads from bus (Li)
//   o_ir_send_address 1  IR drives low nibble to bus (Ei)
//   o_a_load          1  A loads from bus (La)
//   o_a_out           1  A drives bus (Ea)
//   o_alu_sub         1  ALU subtract select (Su)
//   o_alu_out         1  ALU drives bus (Eu)
//   o_b_load          1  B loads from bus (Lb)
//   o_out_load        1  OUT register loads from bus (Lo)
// Modports:
//   master : the sequencer (drives the control word, reads the opcode)
//   slave  : the bus agents (drive the opcode, read the control word)
// ---------------------------------------------------------------------------
interface controller_sequencer_if;
  logic [3:0] i_opcode;
  logic       o_pc_inc;
  logic       o_pc_out;
  logic       o_mar_load;
  logic       o_ram_out;
  logic       o_ir_load;
  logic       o_ir_send_address;
  logic       o_a_load;
  logic       o_a_out;
  logic       o_alu_sub;
  logic       o_alu_out;
  logic       o_b_load;
  logic       o_out_load;

  modport master (
    input  i_opcode,
    output o_pc_inc, o_pc_out, o_mar_load, o_ram_out, o_ir_load,
           o_ir_send_address, o_a_load, o_a_out, o_alu_sub, o_alu_out,
           o_b_load, o_out_load
  );

  modport slave (
    output i_opcode,
    input  o_pc_inc, o_pc_out, o_mar_load, o_ram_out, o_ir_load,
           o_ir_send_address, o_a_load, o_a_out, o_alu_sub, o_alu_out,
           o_b_load, o_out_load
  );
endinterface

// File: rtl/controller_sequencer.sv
// ---------------------------------------------------------------------------
// controller_sequencer
// Purpose : SAP-1 controller/sequencer. Steps a one-hot T1..T6 ring counter
//           and decodes the control word from the current T-state and the
//           opcode held in the instruction register. HLT freezes the ring
//           in T4 with a sticky halt flag that only reset clears.
// Ports   :
//   i_clk      in   1  system clock, rising edge
//   i_reset_n  in   1  asynchronous active-low reset
//   i_debug    in   1  simulation trace select; ignored by the hardware
//   bus        master modport of controller_sequencer_if (opcode in,
//                      control word out)
//   o_tstate   out  6  one-hot ring state, bit0=T1 .. bit5=T6
//   o_halt     out  1  sticky halt flag
// Configuration:
//   CTRL_SKIP_NOP_EN  when defined, instructions skip their trailing idle
//                     states: LDA ends after T5, OUT and undefined opcodes
//                     end after T4; ADD/SUB keep all six states. When
//                     undefined every instruction takes six clocks.
// ---------------------------------------------------------------------------
module controller_sequencer (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_debug,
  controller_sequencer_if.master        bus,
  output logic [5:0]                    o_tstate,
  output logic                          o_halt
);

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_t;

  tstate_t r_state;
  logic    r_halt;

  logic w_op_lda;
  logic w_op_add;
  logic w_op_sub;
  logic w_op_out;
  logic w_op_hlt;
  logic w_op_defined;
  logic w_t4_last;
  logic w_t5_last;
  logic w_unused_debug;

  assign w_op_lda     = (bus.i_opcode == OP_LDA);
  assign w_op_add     = (bus.i_opcode == OP_ADD);
  assign w_op_sub     = (bus.i_opcode == OP_SUB);
  assign w_op_out     = (bus.i_opcode == OP_OUT);
  assign w_op_hlt     = (bus.i_opcode == OP_HLT);
  assign w_op_defined = w_op_lda | w_op_add | w_op_sub | w_op_out | w_op_hlt;

  // The trace select only matters to a simulation model; the hardware
  // has nothing to do with it.
  assign w_unused_debug = i_debug;

`ifdef CTRL_SKIP_NOP_EN
  // Instructions whose remaining T-states would be idle return to fetch early.
  assign w_t4_last = w_op_out | ~w_op_defined;
  assign w_t5_last = w_op_lda;
`else
  assign w_t4_last = 1'b0;
  assign w_t5_last = 1'b0;
`endif

  // Ring counter and halt flag. HLT is recognised on the edge leaving T4:
  // the ring stays parked in T4 and every later clock is ignored.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= T1;
      r_halt  <= 1'b0;
    end else if (!r_halt) begin
      case (r_state)
        T1: r_state <= T2;
        T2: r_state <= T3;
        T3: r_state <= T4;
        T4: begin
          if (w_op_hlt) begin
            r_halt <= 1'b1;
          end else if (w_t4_last) begin
            r_state <= T1;
          end else begin
            r_state <= T5;
          end
        end
        T5: r_state <= w_t5_last ? T1 : T6;
        T6: r_state <= T1;
        default: r_state <= T1;  // recover from a non one-hot value
      endcase
    end
  end

  assign o_tstate = r_state;
  assign o_halt   = r_halt;

  // Moore control word per T-state. Gated by the reset pin as well as the
  // halt flag so nothing drives the bus while reset is held, even though
  // the ring already sits in T1 then.
  always_comb begin
    bus.o_pc_inc          = 1'b0;
    bus.o_pc_out          = 1'b0;
    bus.o_mar_load        = 1'b0;
    bus.o_ram_out         = 1'b0;
    bus.o_ir_load         = 1'b0;
    bus.o_ir_send_address = 1'b0;
    bus.o_a_load          = 1'b0;
    bus.o_a_out           = 1'b0;
    bus.o_alu_sub         = 1'b0;
    bus.o_alu_out         = 1'b0;
    bus.o_b_load          = 1'b0;
    bus.o_out_load        = 1'b0;
    if (i_reset_n && !r_halt) begin
      case (r_state)
        T1: begin
          bus.o_pc_out   = 1'b1;
          bus.o_mar_load = 1'b1;
        end
        T2: begin
          bus.o_pc_inc = 1'b1;
        end
        T3: begin
          bus.o_ram_out = 1'b1;
          bus.o_ir_load = 1'b1;
        end
        T4: begin
          if (w_op_lda | w_op_add | w_op_sub) begin
            bus.o_ir_send_address = 1'b1;
            bus.o_mar_load        = 1'b1;
          end else if (w_op_out) begin
            bus.o_a_out    = 1'b1;
            bus.o_out_load = 1'b1;
          end
        end
        T5: begin
          if (w_op_lda) begin
            bus.o_ram_out = 1'b1;
            bus.o_a_load  = 1'b1;
          end else if (w_op_add | w_op_sub) begin
            bus.o_ram_out = 1'b1;
            bus.o_b_load  = 1'b1;
          end
        end
        T6: begin
          if (w_op_add | w_op_sub) begin
            bus.o_alu_sub = w_op_sub;
            bus.o_alu_out = 1'b1;
            bus.o_a_load  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controller_sequencer.sv
// ---------------------------------------------------------------------------
// tb_controller_sequencer
// Directed bench for controller_sequencer. A T-state/halt model written
// with plain integers runs alongside the DUT and a compare process checks
// the ring state, halt flag, control word and bus-driver count on every
// falling edge. Literal expectations pin the model for LDA, ADD, SUB, OUT,
// a NOP opcode, instruction lengths, mid-instruction reset and HLT.
// ---------------------------------------------------------------------------
module tb_controller_sequencer;

  // Control word packing used throughout the bench.
  localparam logic [11:0] C_PC_INC   = 12'h800;
  localparam logic [11:0] C_PC_OUT   = 12'h400;
  localparam logic [11:0] C_MAR_LOAD = 12'h200;
  localparam logic [11:0] C_RAM_OUT  = 12'h100;
  localparam logic [11:0] C_IR_LOAD  = 12'h080;
  localparam logic [11:0] C_IR_SEND  = 12'h040;
  localparam logic [11:0] C_A_LOAD   = 12'h020;
  localparam logic [11:0] C_A_OUT    = 12'h010;
  localparam logic [11:0] C_ALU_SUB  = 12'h008;
  localparam logic [11:0] C_ALU_OUT  = 12'h004;
  localparam logic [11:0] C_B_LOAD   = 12'h002;
  localparam logic [11:0] C_OUT_LOAD = 12'h001;

`ifdef CTRL_SKIP_NOP_EN
  localparam int LEN_LDA = 5;
  localparam int LEN_NOP = 4;
`else
  localparam int LEN_LDA = 6;
  localparam int LEN_NOP = 6;
`endif
  localparam int LEN_ARITH = 6;

  logic       clk;
  logic       rst_n;
  logic       debug;
  logic [5:0] dut_tstate;
  logic       dut_halt;
  logic       chk_en;

  controller_sequencer_if bus_if();

  controller_sequencer dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_debug   (debug),
    .bus       (bus_if),
    .o_tstate  (dut_tstate),
    .o_halt    (dut_halt)
  );

  logic [11:0] dut_ctrl;
  assign dut_ctrl = {bus_if.o_pc_inc, bus_if.o_pc_out, bus_if.o_mar_load,
                     bus_if.o_ram_out, bus_if.o_ir_load, bus_if.o_ir_send_address,
                     bus_if.o_a_load, bus_if.o_a_out, bus_if.o_alu_sub,
                     bus_if.o_alu_out, bus_if.o_b_load, bus_if.o_out_load};

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_t    = 1;   // current T-state number, 1..6
  bit m_halt = 1'b0;

  function automatic int model_next(input int t, input logic [3:0] op);
    bit nop_op;
    nop_op = !(op inside {4'h0, 4'h1, 4'h2, 4'hF});  // OUT or undefined
`ifdef CTRL_SKIP_NOP_EN
    if (t == 4 && nop_op) return 1;
    if (t == 5 && op == 4'h0) return 1;
`else
    if (nop_op) begin end
`endif
    return (t == 6) ? 1 : t + 1;
  endfunction

  function automatic logic [11:0] model_ctrl(input int t, input logic [3:0] op);
    case (t)
      1: return C_PC_OUT | C_MAR_LOAD;
      2: return C_PC_INC;
      3: return C_RAM_OUT | C_IR_LOAD;
      4: if (op inside {4'h0, 4'h1, 4'h2}) return C_IR_SEND | C_MAR_LOAD;
         else if (op == 4'hE)            return C_A_OUT | C_OUT_LOAD;
         else                            return 12'h000;
      5: if (op == 4'h0)                  return C_RAM_OUT | C_A_LOAD;
         else if (op inside {4'h1, 4'h2}) return C_RAM_OUT | C_B_LOAD;
         else                             return 12'h000;
      6: if (op == 4'h1)      return C_ALU_OUT | C_A_LOAD;
         else if (op == 4'h2) return C_ALU_SUB | C_ALU_OUT | C_A_LOAD;
         else                 return 12'h000;
      default: return 12'h000;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t    <= 1;
      m_halt <= 1'b0;
    end else if (!m_halt) begin
      if (m_t == 4 && bus_if.i_opcode == 4'hF) m_halt <= 1'b1;
      else m_t <= model_next(m_t, bus_if.i_opcode);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      logic [11:0] e_ctrl;
      logic [5:0]  e_ts;
      int          drivers;
      e_ctrl = (rst_n && !m_halt) ? model_ctrl(m_t, bus_if.i_opcode) : 12'h000;
      e_ts   = 6'd1 << (m_t - 1);
      drivers = $countones({bus_if.o_pc_out, bus_if.o_ram_out, bus_if.o_ir_send_address,
                            bus_if.o_a_out, bus_if.o_alu_out});
      chk("cyc_tstate", 32'(dut_tstate), 32'(e_ts));
      chk("cyc_halt", 32'(dut_halt), 32'(m_halt));
      chk("cyc_ctrl", 32'(dut_ctrl), 32'(e_ctrl));
      chk("cyc_bus_drivers_le1", 32'(drivers <= 1), 32'd1);
    end
  end

  // ---------------- directed stimulus ----------------
  logic [11:0] obs[12];
  int          len;

  // Call just after a falling edge with the ring in T1. Presents the opcode,
  // records the control word of each T-state until T1 comes round again.
  task automatic run_instr(input logic [3:0] op);
    bus_if.i_opcode = op;
    #1;
    obs[0] = dut_ctrl;
    len = 1;
    forever begin
      @(negedge clk);
      if (dut_tstate == 6'b000001 || len >= 12) break;
      obs[len] = dut_ctrl;
      len++;
    end
    if (len >= 12) begin
      n_checks++;
      n_errors++;
      $display("FAIL instr_timeout: op %b did not return to T1 within 12 clocks", op);
    end
    #1;
  endtask

  function automatic int exp_len(input logic [3:0] op);
    if (op == 4'h0) return LEN_LDA;
    if (op == 4'h1 || op == 4'h2) return LEN_ARITH;
    return LEN_NOP;
  endfunction

  initial begin
    rst_n = 1'b1;
    debug = 1'b0;
    chk_en = 1'b0;
    bus_if.i_opcode = 4'h0;
    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_tstate", 32'(dut_tstate), 32'h01);
    chk("rst_ctrl", 32'(dut_ctrl), 32'h000);
    chk("rst_halt", 32'(dut_halt), 32'h0);
    #1 rst_n = 1'b1;

    // LDA, every T-state pinned
    run_instr(4'h0);
    $display("instr LDA len=%0d", len);
    chk("lda_len", 32'(len), 32'(LEN_LDA));
    chk("lda_t1", 32'(obs[0]), 32'h600);
    chk("lda_t2", 32'(obs[1]), 32'h800);
    chk("lda_t3", 32'(obs[2]), 32'h180);
    chk("lda_t4", 32'(obs[3]), 32'h240);
    chk("lda_t5", 32'(obs[4]), 32'h120);
`ifndef CTRL_SKIP_NOP_EN
    chk("lda_t6", 32'(obs[5]), 32'h000);
`endif

    run_instr(4'h2);
    $display("instr SUB len=%0d t6=%h", len, obs[5]);
    chk("sub_len", 32'(len), 32'd6);
    chk("sub_t5", 32'(obs[4]), 32'h102);
    chk("sub_t6", 32'(obs[5]), 32'h02C);

    run_instr(4'h1);
    $display("instr ADD len=%0d t6=%h", len, obs[5]);
    chk("add_len", 32'(len), 32'd6);
    chk("add_t6", 32'(obs[5]), 32'h024);

    run_instr(4'hE);
    $display("instr OUT len=%0d", len);
    chk("out_len", 32'(len), 32'(LEN_NOP));
    chk("out_t4", 32'(obs[3]), 32'h011);

    run_instr(4'h7);
    $display("instr NOP(0111) len=%0d", len);
    chk("nop_len", 32'(len), 32'(LEN_NOP));
    for (int k = 3; k < len; k++) chk("nop_ctrl_zero", 32'(obs[k]), 32'h000);

    // Every non-halting opcode: length, with the compare process checking
    // decode and bus contention on each cycle.
    for (int op = 0; op < 15; op++) begin
      run_instr(4'(op));
      $display("instr op=%b len=%0d", 4'(op), len);
      chk("sweep_len", 32'(len), 32'(exp_len(4'(op))));
    end

    // Reset in the middle of an ADD
    bus_if.i_opcode = 4'h1;
    repeat (3) @(negedge clk);
    chk("mid_at_t4", 32'(dut_tstate), 32'h08);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_tstate", 32'(dut_tstate), 32'h01);
    chk("mid_rst_ctrl", 32'(dut_ctrl), 32'h000);
    @(negedge clk);
    #1 rst_n = 1'b1;
    run_instr(4'h0);
    $display("instr LDA after reset len=%0d", len);
    chk("mid_refetch_len", 32'(len), 32'(LEN_LDA));

    // HLT
    bus_if.i_opcode = 4'hF;
    repeat (3) @(negedge clk);
    chk("hlt_t4_ctrl", 32'(dut_ctrl), 32'h000);
    @(negedge clk);
    chk("hlt_set", 32'(dut_halt), 32'h1);
    #1 bus_if.i_opcode = 4'h0;
    repeat (20) @(negedge clk);
    $display("instr HLT tstate=%b halt=%b", dut_tstate, dut_halt);
    chk("hlt_tstate", 32'(dut_tstate), 32'h08);
    chk("hlt_sticky", 32'(dut_halt), 32'h1);
    chk("hlt_ctrl", 32'(dut_ctrl), 32'h000);
    #1 rst_n = 1'b0;
    #1;
    chk("hlt_rst_halt", 32'(dut_halt), 32'h0);
    chk("hlt_rst_tstate", 32'(dut_tstate), 32'h01);
    @(negedge clk);
    #1 rst_n = 1'b1;
    run_instr(4'h1);
    $display("instr ADD after halt len=%0d", len);
    chk("post_hlt_len", 32'(len), 32'd6);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
